// File: rtl/arm_control_stage_pkg.sv
// Shared encodings for the ARM control stage: opcodes, execute commands, condition
// codes, FSM states and the registered control word.
package arm_control_stage_pkg;

  localparam logic [1:0] MODE_ALU = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_CMP = EXE_SUB;
  localparam logic [3:0] EXE_TST = EXE_AND;
  localparam logic [3:0] EXE_LDR = EXE_ADD;
  localparam logic [3:0] EXE_STR = EXE_ADD;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MEM_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       branch;
    logic [3:0] exeCmd;
    logic       sOut;
    logic       wbEn;
    logic       memRead;
    logic       memWrite;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/arm_control_stage_if.sv
// Instruction, pipeline-control and memory-handshake bundle of the ARM control stage.
interface arm_control_stage_if #(parameter int CMD_W = 4);
  logic             valid_in;
  logic             ready_out;
  logic             S;
  logic [1:0]       mode;
  logic [3:0]       opCode;
  logic [3:0]       cond;
  logic [3:0]       status;
  logic             stall;
  logic             flush;
  logic             mem_ready;
  logic             valid_out;
  logic             B;
  logic [CMD_W-1:0] exe_cmd;
  logic             S_out;
  logic             wb_en;
  logic             mem_read;
  logic             mem_write;
  logic             mem_req;
  logic             mem_err;

  modport slave (
    input  valid_in, S, mode, opCode, cond, status, stall, flush, mem_ready,
    output ready_out, valid_out, B, exe_cmd, S_out, wb_en, mem_read, mem_write,
           mem_req, mem_err
  );

  modport master (
    output valid_in, S, mode, opCode, cond, status, stall, flush, mem_ready,
    input  ready_out, valid_out, B, exe_cmd, S_out, wb_en, mem_read, mem_write,
           mem_req, mem_err
  );
endinterface

// File: rtl/arm_control_stage_cond_check.sv
// Evaluates the ARM condition field against the {N,Z,C,V} flags.
module arm_control_stage_cond_check
  import arm_control_stage_pkg::*;
#(
  parameter int COND_EN = 1
) (
  input  logic [3:0] i_cond,
  input  logic [3:0] i_status,
  output logic       o_pass
);

  logic w_n, w_z, w_c, w_v;
  logic w_raw;

  assign {w_n, w_z, w_c, w_v} = i_status;

  always_comb begin
    w_raw = 1'b0;
    case (i_cond)
      COND_EQ: w_raw = w_z;
      COND_NE: w_raw = !w_z;
      COND_CS: w_raw = w_c;
      COND_CC: w_raw = !w_c;
      COND_MI: w_raw = w_n;
      COND_PL: w_raw = !w_n;
      COND_VS: w_raw = w_v;
      COND_VC: w_raw = !w_v;
      COND_HI: w_raw = w_c && !w_z;
      COND_LS: w_raw = !w_c || w_z;
      COND_GE: w_raw = (w_n == w_v);
      COND_LT: w_raw = (w_n != w_v);
      COND_GT: w_raw = !w_z && (w_n == w_v);
      COND_LE: w_raw = w_z || (w_n != w_v);
      COND_AL: w_raw = 1'b1;
      default: w_raw = 1'b0;
    endcase
  end

  // With condition evaluation disabled every instruction behaves as AL, including 1111.
  assign o_pass = (COND_EN != 0) ? w_raw : 1'b1;

endmodule

// File: rtl/arm_control_stage.sv
// Registered ID/EXE control stage: decode, condition gating, stall/flush handling and
// a LDR/STR memory handshake with timeout.
module arm_control_stage
  import arm_control_stage_pkg::*;
#(
  parameter int CMD_W       = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int COND_EN     = 1
) (
  input  logic                clk,
  input  logic                rst,
  arm_control_stage_if.slave  bus
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t           r_state, w_stateNext;
  ctrl_t            r_ctrl, w_ctrlNext, w_dec;
  logic [CNT_W-1:0] r_cnt, w_cntNext;
  logic             r_memErr, w_memErrNext;
  logic             w_pass, w_known, w_isMem;

  arm_control_stage_cond_check #(.COND_EN(COND_EN)) u_cond_check (
    .i_cond   (bus.cond),
    .i_status (bus.status),
    .o_pass   (w_pass)
  );

  always_comb begin
    w_dec   = CTRL_BUBBLE;
    w_known = 1'b0;
    case (bus.mode)
      MODE_ALU: begin
        w_known    = 1'b1;
        w_dec.wbEn = 1'b1;
        w_dec.sOut = bus.S;
        case (bus.opCode)
          OP_MOV:  w_dec.exeCmd = EXE_MOV;
          OP_MVN:  w_dec.exeCmd = EXE_MVN;
          OP_ADD:  w_dec.exeCmd = EXE_ADD;
          OP_ADC:  w_dec.exeCmd = EXE_ADC;
          OP_SUB:  w_dec.exeCmd = EXE_SUB;
          OP_SBC:  w_dec.exeCmd = EXE_SBC;
          OP_AND:  w_dec.exeCmd = EXE_AND;
          OP_ORR:  w_dec.exeCmd = EXE_ORR;
          OP_EOR:  w_dec.exeCmd = EXE_EOR;
          OP_CMP: begin
            w_dec.exeCmd = EXE_CMP;
            w_dec.wbEn   = 1'b0;
            w_dec.sOut   = 1'b1;
          end
          OP_TST: begin
            w_dec.exeCmd = EXE_TST;
            w_dec.wbEn   = 1'b0;
            w_dec.sOut   = 1'b1;
          end
          default: w_known = 1'b0;
        endcase
      end
      // Loads and stores share the ADD opcode; S acts as the L bit.
      MODE_MEM: begin
        if (bus.opCode == OP_ADD) begin
          w_known = 1'b1;
          if (bus.S) begin
            w_dec.exeCmd  = EXE_LDR;
            w_dec.wbEn    = 1'b1;
            w_dec.memRead = 1'b1;
          end else begin
            w_dec.exeCmd   = EXE_STR;
            w_dec.memWrite = 1'b1;
          end
        end
      end
      MODE_BR: begin
        w_known      = 1'b1;
        w_dec.branch = 1'b1;
        w_dec.exeCmd = EXE_NOP;
      end
      default: w_known = 1'b0;
    endcase
    w_dec.valid = 1'b1;
    if (!(w_known && w_pass)) w_dec = CTRL_BUBBLE;
  end

  assign w_isMem = w_dec.memRead || w_dec.memWrite;

  always_comb begin
    w_stateNext  = r_state;
    w_ctrlNext   = r_ctrl;
    w_cntNext    = r_cnt;
    w_memErrNext = r_memErr;
    if (bus.flush) begin
      w_stateNext = ST_IDLE;
      w_ctrlNext  = CTRL_BUBBLE;
      w_cntNext   = '0;
    end else if (bus.stall) begin
      w_stateNext = r_state;
    end else if (r_state == ST_MEM_WAIT) begin
      if (bus.mem_ready) begin
        w_stateNext      = ST_MEM_DONE;
        w_ctrlNext.valid = 1'b1;
        w_cntNext        = '0;
      end else if (r_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
        w_stateNext  = ST_IDLE;
        w_ctrlNext   = CTRL_BUBBLE;
        w_cntNext    = '0;
        w_memErrNext = 1'b1;
      end else begin
        w_cntNext = r_cnt + 1'b1;
      end
    end else begin
      // IDLE and MEM_DONE both accept; ready_out is high here because stall is low.
      w_stateNext = ST_IDLE;
      w_ctrlNext  = CTRL_BUBBLE;
      w_cntNext   = '0;
      if (bus.valid_in) begin
        w_ctrlNext = w_dec;
        if (w_isMem) begin
          w_ctrlNext.valid = 1'b0;
          w_stateNext      = ST_MEM_WAIT;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_ctrl   <= CTRL_BUBBLE;
      r_cnt    <= '0;
      r_memErr <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_ctrl   <= w_ctrlNext;
      r_cnt    <= w_cntNext;
      r_memErr <= w_memErrNext;
    end
  end

  assign bus.ready_out = (r_state != ST_MEM_WAIT) && !bus.stall;
  assign bus.mem_req   = (r_state == ST_MEM_WAIT);
  assign bus.valid_out = r_ctrl.valid;
  assign bus.B         = r_ctrl.branch;
  assign bus.exe_cmd   = CMD_W'(r_ctrl.exeCmd);
  assign bus.S_out     = r_ctrl.sOut;
  assign bus.wb_en     = r_ctrl.wbEn;
  assign bus.mem_read  = r_ctrl.memRead;
  assign bus.mem_write = r_ctrl.memWrite;
  assign bus.mem_err   = r_memErr;

endmodule
